error_response_ctrl: RTL and testbench
======================================

Name: error_response_ctrl

Overview:
- Sequencer in front of error_response: latches error events from the authentication request parser and prioritises them.
- Drives error_response's Enable and one-hot error lines, then hands each finished error message to the transmit layer via a request/ack handshake.
- Also hosts the Busy timeout: an authentication request left unanswered too long raises a Busy error.

Parameters:
- TIMEOUT_CYCLES, 1000, cycles an outstanding request may wait before a Busy error is queued.
- TIMEOUT_W, 16, width of the timeout counter; TIMEOUT_CYCLES < 2^TIMEOUT_W.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- evt_invalid_req  in  1  single-cycle pulse: invalid request.
- evt_invalid_req_challenge  in  1  pulse: invalid challenge request.
- evt_unsupported_protocol  in  1  pulse: unsupported protocol.
- evt_unspecified  in  1  pulse: unspecified error.
- req_pending  in  1  level: an authentication request awaits a response.
- resp_sent  in  1  pulse: normal response transmitted.
- MSG_ready  in  1  from error_response: header valid.
- tx_ack  in  1  transmitter accepted the message.
- Enable  out  1  to error_response.
- Error_Invalid_Request, Error_Invalid_Request_challenge, Error_Busy, Error_Unsupported_Protocol, Error_Unspecified  out  1 each  one-hot error select to error_response.
- send_req  out  1  request transmitter to take header.
- busy  out  1  controller not in IDLE.
- pending  out  5  queued error bits, order {InvReq, InvReqChal, Busy, Unsup, Unspec}.
- drop_count  out  DROP_W  saturating count of coalesced events.

Behaviour:
- Reset (reset=0, async): all outputs 0, pending=0, timeout counter=0, FSM=IDLE.
- Pending register: each event pulse sets its bit.
  - If the bit is already set, increment drop_count (saturate at all-ones).
  - Events arriving in the same cycle set their bits independently.
  - If a set and a clear hit the same bit in the same cycle, the set wins; the bit stays pending and drop_count is not incremented.
- Priority, highest first: InvReq, InvReqChal, Busy, Unsup, Unspec.
- FSM states: IDLE, BUILD, WAIT_READY, SEND, GAP.
  - IDLE: if pending != 0, register the one-hot of the highest-priority bit onto the Error_* outputs, set Enable=1, go to BUILD. Otherwise hold, with Enable=0 and Error_*=0.
  - BUILD: one cycle for error_response to register the header; go to WAIT_READY. Error_* and Enable held stable.
  - WAIT_READY: when MSG_ready=1, set send_req=1, go to SEND.
  - SEND: hold send_req, Enable and Error_* until tx_ack=1. On that cycle, clear the selected pending bit; next cycle send_req=0, Enable=0, Error_*=0; go to GAP.
  - GAP: one idle cycle (Enable low, so error_response clears its header), then IDLE.
- Error_* lines never change while Enable=1. A higher-priority event arriving mid-message waits for the next IDLE.
- Minimum Enable-to-send_req latency is 2 cycles. Back-to-back messages are spaced by at least the GAP cycle.
- tx_ack outside SEND is ignored. MSG_ready outside WAIT_READY is ignored.
- busy=1 in every state except IDLE.
- Timeout counter:
  - Increments each cycle while req_pending=1 and resp_sent=0.
  - Clears when req_pending=0 or resp_sent=1.
  - When it reaches TIMEOUT_CYCLES-1 it sets the Busy pending bit and wraps to 0. It keeps counting for repeated Busy errors while the request stays outstanding.
- Reset asserted mid-message: immediate return to reset values. The in-flight error is lost and not retried.

Optional Feature:
- ERROR_CTRL_TIMEOUT_EN.
- Defined: timeout counter and automatic Busy generation present as above.
- Undefined: no counter logic; the Busy pending bit never sets; req_pending and resp_sent are unused; Error_Busy is tied 0.

Test Plan:
- Reset, then evt_unsupported_protocol pulse at cycle 5 -> Enable=1 at cycle 6 with Error_Unsupported_Protocol=1; MSG_ready response -> send_req; tx_ack -> pending=00000, busy=0 after GAP.
- evt_unspecified and evt_invalid_req in the same cycle -> InvReq message sent first (pending=10001 then 00001), Unspecified sent second; Error_* stable throughout each Enable window.
- evt_invalid_req pulsed twice while its bit is pending -> drop_count=1; 300 repeats -> drop_count=255 (saturated).
- ERROR_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=10, req_pending held high -> Busy bit set after 10 cycles, Error_Busy message issued; resp_sent pulse at cycle 5 -> no Busy.
- reset driven low while in SEND -> Enable, send_req, Error_* = 0 asynchronously; pending=0; FSM=IDLE after release.
- tx_ack held 0 for 50 cycles in SEND -> send_req, Enable and Error_* held constant; new event only sets pending.

Source files
------------

// File: rtl/error_response_ctrl.sv
// Error event sequencer in front of error_response; prioritises and sends queued errors.
// Optional Busy timeout is built when ERROR_CTRL_TIMEOUT_EN is defined.
module error_response_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMEOUT_W      = 16,
    parameter int DROP_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              evt_invalid_req,
    input  logic              evt_invalid_req_challenge,
    input  logic              evt_unsupported_protocol,
    input  logic              evt_unspecified,
    input  logic              req_pending,
    input  logic              resp_sent,
    input  logic              MSG_ready,
    input  logic              tx_ack,
    output logic              Enable,
    output logic              Error_Invalid_Request,
    output logic              Error_Invalid_Request_challenge,
    output logic              Error_Busy,
    output logic              Error_Unsupported_Protocol,
    output logic              Error_Unspecified,
    output logic              send_req,
    output logic              busy,
    output logic [4:0]        pending,
    output logic [DROP_W-1:0] drop_count
);

    typedef enum logic [2:0] {
        IDLE,
        BUILD,
        WAIT_READY,
        SEND,
        GAP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [4:0]        pend_q;
    logic [4:0]        sel_q;
    logic [4:0]        sel_nx;
    logic [4:0]        pick;
    logic [4:0]        evt;
    logic [4:0]        clr;
    logic [4:0]        drops;
    logic [2:0]        n_drop;
    logic [DROP_W:0]   drop_sum;
    logic              busy_evt;

`ifdef ERROR_CTRL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tcnt;
    logic                 tcnt_hit;

    assign tcnt_hit = (tcnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    assign busy_evt = req_pending && !resp_sent && tcnt_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt <= '0;
        end else if (!req_pending || resp_sent || tcnt_hit) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TIMEOUT_W'(1);
        end
    end

    assign Error_Busy = sel_q[2];
`else
    logic unused_tmo;

    assign busy_evt   = 1'b0;
    assign Error_Busy = 1'b0;
    assign unused_tmo = ^{req_pending, resp_sent, sel_q[2],
                          TIMEOUT_W'(TIMEOUT_CYCLES)};
`endif

    assign evt = {evt_invalid_req, evt_invalid_req_challenge, busy_evt,
                  evt_unsupported_protocol, evt_unspecified};

    // The bit being acknowledged is released; a same-cycle set overrides it.
    assign clr   = (state == SEND && tx_ack) ? sel_q : 5'b0;
    assign drops = evt & pend_q & ~clr;

    always_comb begin
        n_drop = '0;
        for (int i = 0; i < 5; i++) begin
            n_drop = n_drop + {2'b0, drops[i]};
        end
        drop_sum = {1'b0, drop_count} + (DROP_W + 1)'(n_drop);
    end

    always_comb begin
        pick = 5'b0;
        if (pend_q[4])      pick = 5'b10000;
        else if (pend_q[3]) pick = 5'b01000;
        else if (pend_q[2]) pick = 5'b00100;
        else if (pend_q[1]) pick = 5'b00010;
        else if (pend_q[0]) pick = 5'b00001;
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel_q;
        unique case (state)
            IDLE: begin
                if (pend_q != 5'b0) begin
                    sel_nx   = pick;
                    state_nx = BUILD;
                end
            end
            BUILD:      state_nx = WAIT_READY;
            WAIT_READY: if (MSG_ready) state_nx = SEND;
            SEND: begin
                if (tx_ack) begin
                    sel_nx   = 5'b0;
                    state_nx = GAP;
                end
            end
            GAP:        state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sel_q      <= '0;
            pend_q     <= '0;
            drop_count <= '0;
        end else begin
            state      <= state_nx;
            sel_q      <= sel_nx;
            pend_q     <= (pend_q & ~clr) | evt;
            drop_count <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        end
    end

    assign Enable   = (state == BUILD) || (state == WAIT_READY) || (state == SEND);
    assign send_req = (state == SEND);
    assign busy     = (state != IDLE);
    assign pending  = pend_q;

    assign Error_Invalid_Request           = sel_q[4];
    assign Error_Invalid_Request_challenge = sel_q[3];
    assign Error_Unsupported_Protocol      = sel_q[1];
    assign Error_Unspecified               = sel_q[0];

endmodule

// File: tb/tb_error_response_ctrl.sv
// Bench for error_response_ctrl: directed stimulus, message-level model, per-cycle compare.
// Timeout scenarios run only when ERROR_CTRL_TIMEOUT_EN is defined.
module tb_error_response_ctrl;

    localparam int TC = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       evt_invalid_req = 1'b0;
    logic       evt_invalid_req_challenge = 1'b0;
    logic       evt_unsupported_protocol = 1'b0;
    logic       evt_unspecified = 1'b0;
    logic       req_pending = 1'b0;
    logic       resp_sent = 1'b0;
    logic       MSG_ready = 1'b0;
    logic       tx_ack = 1'b0;
    logic       Enable;
    logic       Error_Invalid_Request;
    logic       Error_Invalid_Request_challenge;
    logic       Error_Busy;
    logic       Error_Unsupported_Protocol;
    logic       Error_Unspecified;
    logic       send_req;
    logic       busy;
    logic [4:0] pending;
    logic [7:0] drop_count;
    logic [4:0] err_v;

    int n_chk = 0;
    int n_fail = 0;

    error_response_ctrl #(
        .TIMEOUT_CYCLES(TC),
        .TIMEOUT_W(16),
        .DROP_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .evt_invalid_req(evt_invalid_req),
        .evt_invalid_req_challenge(evt_invalid_req_challenge),
        .evt_unsupported_protocol(evt_unsupported_protocol),
        .evt_unspecified(evt_unspecified),
        .req_pending(req_pending),
        .resp_sent(resp_sent),
        .MSG_ready(MSG_ready),
        .tx_ack(tx_ack),
        .Enable(Enable),
        .Error_Invalid_Request(Error_Invalid_Request),
        .Error_Invalid_Request_challenge(Error_Invalid_Request_challenge),
        .Error_Busy(Error_Busy),
        .Error_Unsupported_Protocol(Error_Unsupported_Protocol),
        .Error_Unspecified(Error_Unspecified),
        .send_req(send_req),
        .busy(busy),
        .pending(pending),
        .drop_count(drop_count)
    );

    assign err_v = {Error_Invalid_Request, Error_Invalid_Request_challenge,
                    Error_Busy, Error_Unsupported_Protocol, Error_Unspecified};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] oh(input int i);
        return 5'(1) << i;
    endfunction

    // Message-level model: which error is on the wire and where it is in its life.
    logic [4:0] m_pend = '0;
    logic [4:0] m_ev;
    logic [4:0] m_clr;
    int         m_drop = 0;
    int         m_msg = 0;
    int         m_hi;
    int         streak = 0;
    bit         m_en = 0;
    bit         m_first = 0;
    bit         m_sreq = 0;
    bit         m_gap = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pend = '0; m_drop = 0; m_msg = 0; streak = 0;
            m_en = 0; m_first = 0; m_sreq = 0; m_gap = 0;
        end else begin
            m_ev = {evt_invalid_req, evt_invalid_req_challenge, 1'b0,
                    evt_unsupported_protocol, evt_unspecified};
`ifdef ERROR_CTRL_TIMEOUT_EN
            if (req_pending && !resp_sent) begin
                streak++;
                if (streak % TC == 0) m_ev[2] = 1'b1;
            end else begin
                streak = 0;
            end
`endif
            m_clr = (m_sreq && tx_ack) ? oh(m_msg) : 5'b0;
            m_drop += $countones(m_ev & m_pend & ~m_clr);
            if (m_drop > 255) m_drop = 255;
            if (!(m_en || m_gap)) begin
                if (m_pend != 0) begin
                    m_hi = 4;
                    while (!m_pend[m_hi]) m_hi--;
                    m_msg = m_hi; m_en = 1; m_first = 1;
                end
            end else if (m_first) begin
                m_first = 0;
            end else if (m_en && !m_sreq) begin
                if (MSG_ready) m_sreq = 1;
            end else if (m_sreq) begin
                if (tx_ack) begin m_sreq = 0; m_en = 0; m_gap = 1; end
            end else begin
                m_gap = 0;
            end
            m_pend = (m_pend & ~m_clr) | m_ev;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("cycle",
                  {11'b0, Enable, send_req, busy, err_v, pending, drop_count},
                  {11'b0, m_en, m_sreq, (m_en || m_gap),
                   (m_en ? oh(m_msg) : 5'b0), m_pend, 8'(m_drop)});
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_evt(input logic [4:0] e);
        evt_invalid_req           = e[4];
        evt_invalid_req_challenge = e[3];
        evt_unsupported_protocol  = e[1];
        evt_unspecified           = e[0];
    endtask

    task automatic pulse(input logic [4:0] e);
        set_evt(e);
        cyc();
        set_evt(5'b0);
    endtask

    task automatic to_send(input logic [4:0] exp_err);
        int k = 0;
        while (!Enable && k < 20) begin cyc(); k++; end
        check("enable_seen", Enable, 1);
        check("err_sel", err_v, exp_err);
        MSG_ready = 1'b1;
        k = 0;
        while (!send_req && k < 20) begin cyc(); k++; end
        MSG_ready = 1'b0;
        check("sreq_seen", send_req, 1);
    endtask

    task automatic finish_msg(input int dly, input logic [4:0] ack_evt);
        cyc(dly);
        tx_ack = 1'b1;
        set_evt(ack_evt);
        cyc();
        tx_ack = 1'b0;
        set_evt(5'b0);
        check("gap_enable", Enable, 0);
        check("gap_busy", busy, 1);
        cyc();
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        cyc(3);
        check("rst_out", {Enable, send_req, busy, err_v},
              8'b0);
        check("rst_pend", pending, 5'b0);
        check("rst_drop", drop_count, 8'd0);
        reset = 1'b1;
        cyc(2);

        // single Unsupported message, stray MSG_ready/tx_ack during BUILD
        pulse(5'b00010);
        check("t1_pend", pending, 5'b00010);
        check("t1_en0", Enable, 0);
        cyc();
        check("t1_en", Enable, 1);
        check("t1_err", err_v, 5'b00010);
        MSG_ready = 1'b1;
        tx_ack = 1'b1;
        cyc();
        tx_ack = 1'b0;
        check("t1_sreq0", send_req, 0);
        cyc();
        check("t1_sreq", send_req, 1);
        MSG_ready = 1'b0;
        tx_ack = 1'b1;
        cyc();
        tx_ack = 1'b0;
        check("t1_pend_clr", pending, 5'b0);
        check("t1_gap_en", Enable, 0);
        check("t1_gap_busy", busy, 1);
        cyc();
        check("t1_idle", busy, 0);

        // simultaneous InvReq + Unspecified
        pulse(5'b10001);
        check("t2_pend", pending, 5'b10001);
        to_send(5'b10000);
        finish_msg(1, 5'b0);
        check("t2_pend2", pending, 5'b00001);
        to_send(5'b00001);
        finish_msg(2, 5'b0);
        check("t2_pend3", pending, 5'b0);

        // coalescing, set/clear collision, saturation
        pulse(5'b10000);
        pulse(5'b10000);
        check("t3_drop1", drop_count, 8'd1);
        to_send(5'b10000);
        finish_msg(0, 5'b10000);
        check("t3_keep", pending, 5'b10000);
        check("t3_drop_keep", drop_count, 8'd1);
        set_evt(5'b10000);
        cyc(300);
        set_evt(5'b0);
        check("t3_sat", drop_count, 8'd255);
        to_send(5'b10000);
        finish_msg(0, 5'b0);
        check("t3_pend", pending, 5'b0);

        // long ack stall with a new event arriving
        pulse(5'b00001);
        to_send(5'b00001);
        cyc(20);
        pulse(5'b10000);
        cyc(30);
        check("t6_sreq", send_req, 1);
        check("t6_en", Enable, 1);
        check("t6_err", err_v, 5'b00001);
        check("t6_pend", pending, 5'b10001);
        finish_msg(0, 5'b0);
        check("t6_pend2", pending, 5'b10000);
        to_send(5'b10000);
        finish_msg(0, 5'b0);

        // reset in SEND
        pulse(5'b00010);
        to_send(5'b00010);
        #2;
        reset = 1'b0;
        #1;
        check("t5_out", {Enable, send_req, busy, err_v}, 8'b0);
        check("t5_pend", pending, 5'b0);
        check("t5_drop", drop_count, 8'd0);
        cyc();
        reset = 1'b1;
        cyc(2);
        check("t5_idle", busy, 0);
        check("t5_pend2", pending, 5'b0);

`ifdef ERROR_CTRL_TIMEOUT_EN
        req_pending = 1'b1;
        cyc(TC - 1);
        check("t4_no_busy_yet", pending, 5'b0);
        cyc();
        check("t4_busy_set", pending, 5'b00100);
        req_pending = 1'b0;
        to_send(5'b00100);
        finish_msg(0, 5'b0);
        req_pending = 1'b1;
        cyc(4);
        resp_sent = 1'b1;
        cyc();
        resp_sent = 1'b0;
        cyc(TC - 1);
        check("t4_resp_clears", pending, 5'b0);
        req_pending = 1'b0;
        cyc(2);
`else
        req_pending = 1'b1;
        cyc(25);
        check("t4_off_pend", pending, 5'b0);
        check("t4_off_err", Error_Busy, 0);
        check("t4_off_busy", busy, 0);
        req_pending = 1'b0;
        cyc(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
